// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the program-counter / return-stack unit.
// Holds the default address width, reset and interrupt vectors, and the
// per-cycle PC operation selected by the command priority encoder.
package cpu_pkg;

  localparam int          ADDR_W_DEF    = 16;
  localparam logic [15:0] RESET_VEC_DEF = 16'h0000;
  localparam logic [15:0] INT_VEC_DEF   = 16'h0004;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD,
    PC_CALL,
    PC_RET,
    PC_IRET,
    PC_INT
  } pc_op_t;

endpackage

// File: rtl/pc_stack_unit_if.sv
// Control-unit <-> PC unit bus.
// master: control unit, drives command strobes, int_req and load_addr,
//         observes i_addr, interrupt status, stack status and fault flags.
// slave : pc_stack_unit.
interface pc_stack_unit_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W_DEF,
  parameter int DEPTH  = 8
);
  localparam int DEPTH_W = $clog2(DEPTH + 1);

  logic              stall;
  logic              increment;
  logic              load;
  logic              call;
  logic              ret;
  logic              iret;
  logic              mask_int;
  logic              unmask_int;
  logic              int_req;
  logic              fault_clr;
  logic [ADDR_W-1:0] load_addr;

  logic [ADDR_W-1:0]  i_addr;
  logic               int_ack;
  logic               int_masked;
  logic [DEPTH_W-1:0] depth;
  logic [ADDR_W-1:0]  tos;
  logic               overflow;
  logic               underflow;

  modport master (
    output stall, increment, load, call, ret, iret, mask_int, unmask_int,
           int_req, fault_clr, load_addr,
    input  i_addr, int_ack, int_masked, depth, tos, overflow, underflow
  );

  modport slave (
    input  stall, increment, load, call, ret, iret, mask_int, unmask_int,
           int_req, fault_clr, load_addr,
    output i_addr, int_ack, int_masked, depth, tos, overflow, underflow
  );
endinterface

// File: rtl/pc_stack_unit_ret_stack.sv
// Hardware return-address stack (LIFO).
// Ports: clk, rst (sync, active-high), push/pop strobes, din (pushed value);
//        tos (top entry, 0 when empty), depth (valid entries), full, empty.
// A push while full and a pop while empty are ignored here; the caller
// records the fault.
module ret_stack #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8,
  localparam int DEPTH_W = $clog2(DEPTH + 1),
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ADDR_W-1:0]  din,
  output logic [ADDR_W-1:0]  tos,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  logic [ADDR_W-1:0]  mem [DEPTH];
  logic [DEPTH_W-1:0] cnt;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;

  // wr_idx is only used when not full, so cnt < DEPTH and the slice is exact.
  assign wr_idx = cnt[IDX_W-1:0];
  assign rd_idx = IDX_W'(cnt - DEPTH_W'(1));

  assign full  = (cnt == DEPTH_W'(DEPTH));
  assign empty = (cnt == '0);
  assign depth = cnt;
  assign tos   = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + DEPTH_W'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - DEPTH_W'(1);
    end
  end

  // Storage needs no reset: entries above cnt are never visible.
  always_ff @(posedge clk) begin
    if (!rst && push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with return-address stack, single-vector interrupt entry,
// interrupt mask and sticky stack-fault flags.
// Ports: clk, rst (sync, active-high), bus (pc_stack_unit_if.slave) carrying
//        command strobes, int_req, load_addr in and i_addr, int_ack,
//        int_masked, depth, tos, overflow, underflow out.
// Exactly one PC operation executes per cycle, chosen by a fixed priority.
module pc_stack_unit
  import cpu_pkg::*;
#(
  parameter int               ADDR_W    = ADDR_W_DEF,
  parameter int               DEPTH     = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [ADDR_W-1:0] INT_VEC   = INT_VEC_DEF
) (
  input logic           clk,
  input logic           rst,
  pc_stack_unit_if.slave bus
);

  localparam int DEPTH_W = $clog2(DEPTH + 1);

  pc_op_t             op;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_next;
  logic [ADDR_W-1:0]  pc_inc;
  logic               masked_q;
  logic               mask_next;
  logic               ack_q;
  logic               ovf_q;
  logic               unf_q;
  logic               int_take;
  logic               push;
  logic               pop;
  logic [ADDR_W-1:0]  push_data;
  logic [ADDR_W-1:0]  stk_tos;
  logic [DEPTH_W-1:0] stk_depth;
  logic               stk_full;
  logic               stk_empty;

  assign pc_inc = pc_q + ADDR_W'(1);

  // Interrupts are only taken on an instruction boundary.
  assign int_take = bus.int_req && !masked_q &&
                    (bus.increment || bus.load || bus.call);

  always_comb begin
    op = PC_HOLD;
    if (!bus.stall) begin
      if (bus.iret)          op = PC_IRET;
      else if (bus.ret)      op = PC_RET;
      else if (int_take)     op = PC_INT;
      else if (bus.call)     op = PC_CALL;
      else if (bus.load)     op = PC_LOAD;
      else if (bus.increment) op = PC_INC;
    end
  end

  assign push = (op == PC_CALL) || (op == PC_INT);
  assign pop  = (op == PC_RET)  || (op == PC_IRET);

  // On interrupt entry the return address is where the interrupted command
  // would have gone; an interrupted call becomes a plain jump.
  assign push_data = ((op == PC_INT) && (bus.call || bus.load)) ? bus.load_addr
                                                                : pc_inc;

  always_comb begin
    pc_next = pc_q;
    case (op)
      PC_INC:           pc_next = pc_inc;
      PC_LOAD, PC_CALL: pc_next = bus.load_addr;
      PC_RET, PC_IRET:  pc_next = stk_empty ? RESET_VEC : stk_tos;
      PC_INT:           pc_next = INT_VEC;
      default:          pc_next = pc_q;
    endcase
  end

  // Later assignments take precedence: set requests beat clear requests.
  always_comb begin
    mask_next = masked_q;
    if (op == PC_IRET)  mask_next = 1'b0;
    if (bus.unmask_int) mask_next = 1'b0;
    if (op == PC_INT)   mask_next = 1'b1;
    if (bus.mask_int)   mask_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_VEC;
      masked_q <= 1'b1;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      pc_q     <= pc_next;
      masked_q <= mask_next;
      ack_q    <= (op == PC_INT);
      ovf_q    <= (ovf_q && !bus.fault_clr) || (push && stk_full);
      unf_q    <= (unf_q && !bus.fault_clr) || (pop && stk_empty);
    end
  end

  ret_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .tos   (stk_tos),
    .depth (stk_depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign bus.i_addr     = pc_q;
  assign bus.int_ack    = ack_q;
  assign bus.int_masked = masked_q;
  assign bus.depth      = stk_depth;
  assign bus.tos        = stk_tos;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised successor to the program counter. Adds a DEPTH-entry hardware return-address stack, single-vector interrupt entry with mask, iret, and sticky stack-fault flags.
- Drives i_addr to instruction memory.
- The control unit issues one-cycle command strobes. Interrupt request comes from IO.

Parameters:
ADDR_W, 16, width of i_addr, load_addr and stack entries
DEPTH, 8, return-stack entries (>=2)
RESET_VEC, 0, i_addr after reset and after underflow
INT_VEC, 16'h0004, interrupt entry address

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  freeze PC, stack, mask; blocks interrupt entry
increment  in  1  PC <= PC+1
load  in  1  PC <= load_addr
call  in  1  push PC+1, PC <= load_addr
ret  in  1  PC <= pop
iret  in  1  PC <= pop, clear mask
mask_int  in  1  set interrupt mask
unmask_int  in  1  clear interrupt mask
int_req  in  1  level interrupt request
fault_clr  in  1  clear overflow/underflow
load_addr  in  ADDR_W  jump/call target
i_addr  out  ADDR_W  current PC (registered)
int_ack  out  1  one-cycle pulse: interrupt taken
int_masked  out  1  mask state
depth  out  $clog2(DEPTH+1)  valid stack entries
tos  out  ADDR_W  top-of-stack value, 0 when empty
overflow  out  1  sticky: push while full
underflow  out  1  sticky: pop while empty

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: i_addr=RESET_VEC, depth=0, tos=0, int_masked=1, int_ack=0, overflow=0, underflow=0. Reset mid-call or mid-interrupt discards all stack contents.
- Latency: all outputs are registered. A command sampled at edge N is visible on i_addr after edge N.
- Command priority (lowest command wins nothing; only the highest asserted command executes): rst > stall > ret/iret > interrupt entry > call > load > increment > hold.
- ret and iret together: iret wins.
- Hold (no command): i_addr unchanged.
- Arithmetic: PC+1 wraps modulo 2^ADDR_W, so 16'hFFFF+1 = 0.
- Interrupt entry condition: int_req=1, int_masked=0, stall=0, no ret/iret, and at least one of increment/load/call asserted (instruction boundary).
- Interrupt entry actions:
  - Push the address the command would have produced: PC+1, or load_addr for load/call.
  - If the command was call, the call's own push is dropped. The call is treated as a jump; software re-executes nothing.
  - i_addr <= INT_VEC, int_masked <= 1, int_ack=1 for exactly one cycle.
- Deferral: an interrupt coinciding with ret/iret is deferred to the next eligible cycle.
- Stack: LIFO with push at index depth and pop from depth-1.
  - Simultaneous push and pop never occurs; priority guarantees a single operation.
- Full push (depth==DEPTH): push discarded, depth unchanged, overflow<=1, PC still jumps.
- Empty pop (depth==0): i_addr <= RESET_VEC, underflow<=1, depth stays 0. For iret, the mask is still cleared.
- Mask updates:
  - mask_int and unmask_int together: mask wins.
  - Interrupt entry overrides a same-cycle unmask_int (mask=1).
  - iret clears the mask unless mask_int is asserted the same cycle.
  - mask_int/unmask_int are honoured during stall.
- fault_clr clears both sticky flags. A new fault in the same cycle wins (flag=1).
- int_masked=1 blocks nesting. Software may unmask inside a handler to nest up to DEPTH levels.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W default, RESET_VEC, INT_VEC constants.
  - Enum pc_op_t {PC_HOLD, PC_INC, PC_LOAD, PC_CALL, PC_RET, PC_IRET, PC_INT}, produced by a priority encoder inside this block.
- Sub-module ret_stack (params ADDR_W, DEPTH):
  - Inputs: push, pop, din.
  - Outputs: tos, depth, full, empty.
  - Registered, synchronous reset to empty.

Test Plan:
- Reset then 3 cycles of increment → i_addr 0,1,2,3. Assert increment at 16'hFFFF → i_addr 0.
- call with load_addr=16'h0100 at PC 16'h0010 → i_addr 16'h0100, depth 1, tos 16'h0011. Then ret → i_addr 16'h0011, depth 0.
- unmask_int, then int_req=1 with increment at PC 16'h0020 → i_addr 16'h0004, int_ack pulses 1 cycle, tos 16'h0021, int_masked=1. Then iret → i_addr 16'h0021, int_masked=0.
- DEPTH=4: five calls to 16'h0200 → depth 4, overflow=1, i_addr 16'h0200. Five rets → fifth goes to RESET_VEC, underflow=1. Then fault_clr → both flags 0.
- int_req=1 with ret asserted in the same cycle (unmasked) → ret executes, int_ack=0. Next increment cycle → interrupt taken.
- stall=1 with increment and int_req=1, unmasked → i_addr, depth unchanged, int_ack=0. Then rst mid-handler → i_addr 0, depth 0, int_masked=1.
